// File: rtl/hist_pkg.sv
// Shared constants and FSM state type for the histogram host-readout path.
package hist_pkg;

  localparam int N_HISTO_DEF = 8;
  localparam int N_IPI_DEF   = 64;
  localparam int WORD_W_DEF  = 32;
  localparam int IDX_W       = 7;

  localparam logic [7:0] FRAME_HDR      = 8'hA5;
  localparam logic [7:0] CMD_READ       = 8'h01;
  localparam logic [7:0] CMD_READ_CLEAR = 8'h02;
  localparam logic [7:0] CMD_CLEAR      = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_BYTE,
    ST_CSUM,
    ST_CLEAR
  } state_t;

endpackage

// File: rtl/hist_word_mux.sv
// Selects one histogram word by flat index: channel counts first, then interval bins.
module hist_word_mux
  import hist_pkg::*;
#(
  parameter int N_HISTO = N_HISTO_DEF,
  parameter int N_IPI   = N_IPI_DEF,
  parameter int WORD_W  = WORD_W_DEF
) (
  input  logic [N_HISTO-1:0][WORD_W-1:0] histo,
  input  logic [N_IPI-1:0][WORD_W-1:0]   ipihist,
  input  logic [IDX_W-1:0]               idx,
  output logic [WORD_W-1:0]              word
);

  localparam int N_SLOT = 2 ** IDX_W;

  // Full power-of-two table so every index value is in range; spare slots read zero.
  logic [WORD_W-1:0] slot [N_SLOT];

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOT; gi++) begin : g_slot
      if (gi < N_HISTO) begin : g_histo
        assign slot[gi] = histo[gi];
      end else if (gi < N_HISTO + N_IPI) begin : g_ipi
        assign slot[gi] = ipihist[gi - N_HISTO];
      end else begin : g_zero
        assign slot[gi] = '0;
      end
    end
  endgenerate

  assign word = slot[idx];

endmodule

// File: rtl/hist_readout.sv
// Host-command driven serialiser: frames all histogram words as little-endian bytes
// with header and XOR checksum, optionally followed by a histogram-clear pulse.
module hist_readout
  import hist_pkg::*;
#(
  parameter int N_HISTO = N_HISTO_DEF,
  parameter int N_IPI   = N_IPI_DEF,
  parameter int WORD_W  = WORD_W_DEF
) (
  input  logic                           clkin,
  input  logic                           rstn,
  input  logic [N_HISTO-1:0][WORD_W-1:0] histo,
  input  logic [N_IPI-1:0][WORD_W-1:0]   ipihist,
  input  logic                           rx_valid,
  input  logic [7:0]                     rx_data,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic                           resethist,
  output logic                           busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HISTO + N_IPI - 1);

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [1:0]        bcnt_reg;
  logic [WORD_W-1:0] shreg_reg;
  logic [7:0]        csum_reg;
  logic              rdclr_reg;
  logic [WORD_W-1:0] word_sel;

  hist_word_mux #(
    .N_HISTO (N_HISTO),
    .N_IPI   (N_IPI),
    .WORD_W  (WORD_W)
  ) u_word_mux (
    .histo   (histo),
    .ipihist (ipihist),
    .idx     (idx_reg),
    .word    (word_sel)
  );

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Outputs decode straight from state so tx_data/tx_valid hold while stalled.
  always_comb begin
    state_next = state_reg;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    resethist  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (rx_valid) begin
          if (rx_data == CMD_READ || rx_data == CMD_READ_CLEAR) state_next = ST_HDR;
          else if (rx_data == CMD_CLEAR)                        state_next = ST_CLEAR;
        end
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = FRAME_HDR;
        if (tx_ready) state_next = ST_LOAD;
      end
      ST_LOAD: state_next = ST_BYTE;
      ST_BYTE: begin
        tx_valid = 1'b1;
        tx_data  = shreg_reg[7:0];
        if (tx_ready && bcnt_reg == 2'd3)
          state_next = (idx_reg == LAST_IDX) ? ST_CSUM : ST_LOAD;
      end
      ST_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_reg;
        if (tx_ready) state_next = rdclr_reg ? ST_CLEAR : ST_IDLE;
      end
      ST_CLEAR: begin
        resethist  = 1'b1;
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      idx_reg   <= '0;
      bcnt_reg  <= '0;
      shreg_reg <= '0;
      csum_reg  <= '0;
      rdclr_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rx_valid && (rx_data == CMD_READ || rx_data == CMD_READ_CLEAR))
            rdclr_reg <= (rx_data == CMD_READ_CLEAR);
        end
        ST_HDR: begin
          if (tx_ready) begin
            idx_reg  <= '0;
            csum_reg <= FRAME_HDR;
          end
        end
        ST_LOAD: begin
          shreg_reg <= word_sel;
          bcnt_reg  <= '0;
        end
        ST_BYTE: begin
          if (tx_ready) begin
            shreg_reg <= shreg_reg >> 8;
            csum_reg  <= csum_reg ^ shreg_reg[7:0];
            bcnt_reg  <= bcnt_reg + 2'd1;
            if (bcnt_reg == 2'd3 && idx_reg != LAST_IDX) idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hist_readout.sv
// Scoreboard bench for hist_readout: expected frame bytes are queued at command time
// and a negedge monitor pops and compares on every tx handshake.
module tb_hist_readout;

  localparam int NH = 8;
  localparam int NI = 64;

  logic                 clkin = 1'b0;
  logic                 rstn;
  logic [NH-1:0][31:0]  histo_v;
  logic [NI-1:0][31:0]  ipi_v;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 resethist;
  logic                 busy;

  hist_readout #(.N_HISTO(NH), .N_IPI(NI), .WORD_W(32)) dut (
    .clkin     (clkin),
    .rstn      (rstn),
    .histo     (histo_v),
    .ipihist   (ipi_v),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .resethist (resethist),
    .busy      (busy)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         rx_cnt = 0;
  int         rh_cnt = 0;
  int         rh_cyc = 0;
  int         last_hs_cyc = 0;
  int         issue_cyc = 0;
  int         idle_cyc = 0;
  logic [7:0] frame_xor = 8'h00;
  logic [7:0] last_byte = 8'h00;
  logic [39:0] last5 = '0;
  logic       rnd_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected frame from the bench's own input words.
  task automatic push_frame();
    logic [7:0]  x;
    logic [31:0] w;
    x = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NH + NI; i++) begin
      w = (i < NH) ? histo_v[i] : ipi_v[i - NH];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
        x ^= w[8*b +: 8];
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(posedge clkin); #2;
    rx_valid  = 1'b1;
    rx_data   = b;
    issue_cyc = cyc;
    $display("cmd %02h issued at cycle %0d (busy=%0b)", b, cyc, busy);
    @(posedge clkin); #2;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
  endtask

  task automatic wait_idle(input int bound);
    bit done = 0;
    for (int k = 0; k < bound && !done; k++) begin
      @(negedge clkin);
      if (exp_q.size() == 0 && !busy) begin
        done = 1;
        idle_cyc = cyc;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_idle: timeout after %0d cycles, %0d bytes pending", bound, exp_q.size());
    end
  endtask

  // tx_ready: held high, or pseudo-random when rnd_mode is set
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clkin); #2;
      tx_ready = rnd_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clkin);
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(tx_valid), 64'd1);
          check("hold_data", 64'(tx_data), 64'(prev_data));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got %02h, want no byte (cycle %0d)", tx_data, cyc);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", 64'(tx_data), 64'(e));
          end
          rx_cnt++;
          frame_xor   ^= tx_data;
          last_byte   = tx_data;
          last5       = {last5[31:0], tx_data};
          last_hs_cyc = cyc;
        end
        if (resethist) begin
          rh_cnt++;
          rh_cyc = cyc;
          check("busy_during_clear", 64'(busy), 64'd0);
        end
      end
    end
  end

  initial begin
    int base_rx;
    int base_rh;
    bit hit;
    rstn     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    histo_v  = '0;
    ipi_v    = '0;

    // Reset state
    @(negedge clkin);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'h00);
    check("rst_resethist", 64'(resethist), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clkin);
    #2 rstn = 1'b1;

    // READ with histo[0]=0x11223344
    histo_v[0] = 32'h11223344;
    push_frame();
    base_rh = rh_cnt;
    send_cmd(8'h01);
    @(negedge clkin);
    check("hdr_latency_valid", 64'(tx_valid), 64'd1);
    check("hdr_latency_data", 64'(tx_data), 64'hA5);
    wait_idle(1000);
    check("t1_checksum", 64'(last_byte), 64'hE1);
    check("t1_frame_cycles", 64'(last_hs_cyc - issue_cyc), 64'd362);
    check("t1_busy_drop", 64'(idle_cyc - last_hs_cyc), 64'd1);
    repeat (3) @(negedge clkin);
    check("t1_no_clear", 64'(rh_cnt - base_rh), 64'd0);

    // READ_CLEAR with all words zero
    histo_v = '0;
    push_frame();
    base_rh = rh_cnt;
    base_rx = rx_cnt;
    send_cmd(8'h02);
    wait_idle(1000);
    repeat (4) @(negedge clkin);
    check("t2_checksum", 64'(last_byte), 64'hA5);
    check("t2_byte_count", 64'(rx_cnt - base_rx), 64'd290);
    check("t2_clear_pulses", 64'(rh_cnt - base_rh), 64'd1);
    check("t2_clear_timing", 64'(rh_cyc - last_hs_cyc), 64'd1);

    // ipihist[63]=0xDEADBEEF under random backpressure
    ipi_v[63] = 32'hDEADBEEF;
    push_frame();
    frame_xor = 8'h00;
    rnd_mode  = 1'b1;
    send_cmd(8'h01);
    wait_idle(4000);
    rnd_mode = 1'b0;
    check("t3_frame_xor", 64'(frame_xor), 64'h00);
    check("t3_tail_bytes", 64'(last5), 64'hEFBEADDE87);

    // Commands while busy are dropped; unknown byte in IDLE ignored
    ipi_v    = '0;
    push_frame();
    base_rx  = rx_cnt;
    base_rh  = rh_cnt;
    send_cmd(8'h01);
    repeat (20) @(posedge clkin);
    send_cmd(8'h01);
    repeat (50) @(posedge clkin);
    send_cmd(8'h03);
    wait_idle(1000);
    send_cmd(8'h7F);
    @(negedge clkin);
    check("t4_7f_busy", 64'(busy), 64'd0);
    repeat (30) @(negedge clkin);
    check("t4_byte_count", 64'(rx_cnt - base_rx), 64'd290);
    check("t4_no_clear", 64'(rh_cnt - base_rh), 64'd0);

    // CLEAR in IDLE
    base_rh = rh_cnt;
    send_cmd(8'h03);
    @(negedge clkin);
    check("t5_clear_high", 64'(resethist), 64'd1);
    check("t5_tx_quiet", 64'(tx_valid), 64'd0);
    @(negedge clkin);
    check("t5_clear_low", 64'(resethist), 64'd0);
    check("t5_tx_quiet2", 64'(tx_valid), 64'd0);
    check("t5_clear_pulses", 64'(rh_cnt - base_rh), 64'd1);

    // Reset mid-frame of a READ_CLEAR, then a fresh READ
    for (int i = 0; i < NH; i++) histo_v[i] = 32'h01020304 * (i + 1);
    push_frame();
    base_rx = rx_cnt;
    base_rh = rh_cnt;
    send_cmd(8'h02);
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(posedge clkin); #2;
      if (rx_cnt - base_rx >= 100) hit = 1;
    end
    if (!hit) begin
      n_cmp++;
      n_err++;
      $display("FAIL t6_reach_byte100: got %0d bytes, want 100", rx_cnt - base_rx);
    end
    rstn = 1'b0;
    exp_q.delete();
    @(negedge clkin);
    check("t6_rst_valid", 64'(tx_valid), 64'd0);
    check("t6_rst_data", 64'(tx_data), 64'h00);
    check("t6_rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clkin);
    #2 rstn = 1'b1;
    repeat (5) @(negedge clkin);
    check("t6_no_clear_after_abort", 64'(rh_cnt - base_rh), 64'd0);
    push_frame();
    base_rx = rx_cnt;
    send_cmd(8'h01);
    @(negedge clkin);
    check("t6_fresh_hdr", 64'(tx_data), 64'hA5);
    wait_idle(1000);
    repeat (4) @(negedge clkin);
    check("t6_fresh_count", 64'(rx_cnt - base_rx), 64'd290);
    check("t6_no_clear", 64'(rh_cnt - base_rh), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
